alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 6-bit ALU_operation code produced by the ALU control decoder and returns the result on a valid/ready handshake.
- Single-cycle ops (logic, add/sub, shifts, set-less-than) take one cycle. The M-extension multiply family runs on an iterative 32-step shift-add multiplier.
- Sits between the decode/issue logic and the writeback register, and back-pressures issue while busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- MUL_STEPS, 32, multiplier iteration count; must equal XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- in_op  input  6  ALU_operation code.
- in_a  input  32  operand A (rs1).
- in_b  input  32  operand B (rs2 or immediate).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  result.
- out_illegal  output  1  op code unsupported; qualified by out_valid.

Behaviour:
- Op codes (binary) and results:
  - 000000 AND: a&b.
  - 000001 OR: a|b.
  - 000010 ADD: a+b mod 2^32.
  - 000110 SUB: a-b mod 2^32.
  - 000111 XOR: a^b.
  - 001010 signed less-than: 1 if $signed(a)<$signed(b), else 0.
  - 001001 unsigned less-than: 1 if a<b, else 0.
  - 001011 SLL: a<<b[4:0].
  - 001100 SRL: logical a>>b[4:0].
  - 001101 SRA: arithmetic a>>>b[4:0].
  - 010000 MUL: low 32 bits of a*b.
  - 010001 MULH: high 32 bits of signed a × signed b.
  - 010010 MULHSU: high 32 bits of signed a × unsigned b.
  - 010011 MULHU: high 32 bits of unsigned a × unsigned b.
  - Any other code, including 110000/110001 (FP, handled elsewhere) and 111111: out_result=0, out_illegal=1, single-cycle timing.
- Shift amounts use only b[4:0]; b[31:5] is ignored.
- Handshake:
  - Transfer occurs when valid && ready on a rising edge.
  - in_ready = 1 only in IDLE.
  - in_op/in_a/in_b are captured at acceptance; later input changes have no effect.
  - out_valid stays high with out_result/out_illegal stable until out_ready is sampled high.
- FSM states IDLE, MUL, FIX, RESP:
  - IDLE: on accept of a non-multiply op, compute the result and go to RESP. On accept of a multiply op, latch operand magnitudes and the product sign, clear the 64-bit accumulator, set step counter=0, and go to MUL.
  - MUL: each cycle, add the shifted multiplicand when the current multiplier bit is 1; counter++. After step 31 (32 cycles), go to FIX.
  - FIX: negate the 64-bit product if the sign flag is set. Select [31:0] for MUL, [63:32] otherwise. Go to RESP.
  - RESP: out_valid=1. On out_ready, go to IDLE.
- Sign rules:
  - MUL and MULH treat both operands as signed.
  - MULHSU treats only a as signed.
  - MULHU treats neither as signed.
  - Magnitude of 0x80000000 is 2^31, held unsigned in 32 bits.
- Latency, with the accept edge as cycle 0:
  - Non-multiply ops: out_valid high from cycle 1.
  - Multiply ops: MUL occupies cycles 1–32, FIX cycle 33, out_valid high from cycle 34.
  - Throughput: at most one op per 2 cycles; no accept in RESP, even when out_ready=1.
- Reset (async, any state, including mid-multiply):
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, out_illegal=0, counter=0, accumulator=0.
  - On release, the first request is accepted normally.
  - A partial multiply is discarded, never emitted.
- in_valid while busy is ignored (not accepted); the requester holds it.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 → out_valid at cycle 1, result 0x00000000, illegal 0. SUB a=0, b=1 → 0xFFFFFFFF.
- Signed less-than a=0xFFFFFFFF, b=1 → 1. Unsigned less-than, same operands → 0. SRA a=0x80000000, b=0x00000024 → shift 4 → 0xF8000000. SRL, same operands → 0x08000000.
- Multiply with a=0x80000000, b=0x80000000:
  - MUL → 0x00000000.
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU → 0xC0000000.
  - Each with out_valid first high exactly 34 cycles after accept and in_ready low throughout.
- MULH a=0xFFFFFFFF (−1), b=3 → 0xFFFFFFFF. MUL, same operands → 0xFFFFFFFD. MULHU, same operands → 0x00000002.
- in_op=110000 → result 0, out_illegal=1 at cycle 1. Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0. Assert out_ready → in_ready=1 the next cycle.
- Assert rst_n=0 at cycle 10 of a MUL → immediately out_valid=0, in_ready=1. After release, ADD 2+3 → 5 at cycle 1, with no stale multiply result emitted.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU with an iterative shift-add multiplier.
//
// Purpose:
//   Executes one ALU_operation per request. Logic, add/sub, shift and
//   set-less-than ops answer one cycle after acceptance. The multiply family
//   (MUL/MULH/MULHSU/MULHU) runs a 32-step shift-add loop on operand
//   magnitudes, then applies the product sign in a single fix-up cycle.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready. in_ready is high only in IDLE, so a new request is never
//   taken while a result is pending. out_valid holds, with out_result and
//   out_illegal stable, until out_ready is sampled high.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     unit idle, can accept a request
//   in_op[5:0]   ALU_operation code
//   in_a, in_b   operands (rs1, rs2/immediate)
//   out_valid    result available
//   out_ready    consumer accepts the result
//   out_result   result word
//   out_illegal  op code not handled here (qualified by out_valid)
//
// Debug: the FSM state is held in the 'state' signal (type state_t).

module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int CW = $clog2(MUL_STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;   // shifts left one place per step
  logic [XLEN-1:0]     mplier;  // shifts right; bit 0 is the current bit
  logic                neg;     // product must be negated in FIX
  logic                mul_lo;  // op was MUL: return low word

  // ---------------- single-cycle datapath ----------------
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_op)
      6'b000000: alu_res = in_a & in_b;
      6'b000001: alu_res = in_a | in_b;
      6'b000010: alu_res = in_a + in_b;
      6'b000110: alu_res = in_a - in_b;
      6'b000111: alu_res = in_a ^ in_b;
      6'b001010: alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      6'b001001: alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      6'b001011: alu_res = in_a << in_b[4:0];
      6'b001100: alu_res = in_a >> in_b[4:0];
      6'b001101: alu_res = XLEN'($signed(in_a) >>> in_b[4:0]);
      default:   alu_ill = 1'b1;
    endcase
  end

  // ---------------- multiply set-up ----------------
  // 0100xx is the multiply family. a is signed for all but MULHU (xx=11);
  // b is signed only for MUL and MULH (xx=0x).
  logic            is_mul;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_mul = (in_op[5:2] == 4'b0100);
    neg_a  = (in_op[1:0] != 2'b11) && in_a[XLEN-1];
    neg_b  = (in_op[1] == 1'b0) && in_b[XLEN-1];
    // Two's-complement negate; 0x80000000 maps to itself, read as 2^31.
    mag_a  = neg_a ? (~in_a + 1'b1) : in_a;
    mag_b  = neg_b ? (~in_b + 1'b1) : in_b;
  end

  logic [2*XLEN-1:0] fix_prod;
  assign fix_prod = neg ? (~acc + 1'b1) : acc;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_RESP);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
      mul_lo      <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              acc    <= '0;
              cnt    <= '0;
              mcand  <= {{XLEN{1'b0}}, mag_a};
              mplier <= mag_b;
              neg    <= neg_a ^ neg_b;
              mul_lo <= (in_op[1:0] == 2'b00);
              state  <= S_MUL;
            end else begin
              out_result  <= alu_res;
              out_illegal <= alu_ill;
              state       <= S_RESP;
            end
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MUL_STEPS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          out_result  <= mul_lo ? fix_prod[XLEN-1:0] : fix_prod[2*XLEN-1:XLEN];
          out_illegal <= 1'b0;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- self-checking bench for alu_exec_unit.
// Expected results come from a plain-arithmetic reference model (64-bit
// integer products, native shifts/compares) held in an expected queue.

module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic        expi_q[$];

  alu_exec_unit #(.XLEN(32), .MUL_STEPS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r, output logic il);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    il = 1'b0;
    p  = '0;
    case (op)
      6'b000000: r = a & b;
      6'b000001: r = a | b;
      6'b000010: r = a + b;
      6'b000110: r = a - b;
      6'b000111: r = a ^ b;
      6'b001010: r = (sa < sb) ? 32'd1 : 32'd0;
      6'b001001: r = (a < b) ? 32'd1 : 32'd0;
      6'b001011: r = a << b[4:0];
      6'b001100: r = a >> b[4:0];
      6'b001101: r = 32'(sa >>> b[4:0]);
      6'b010000: begin p = 64'(sa * sb); r = p[31:0]; end
      6'b010001: begin p = 64'(sa * sb); r = p[63:32]; end
      6'b010010: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
      6'b010011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      default:   il = 1'b1;
    endcase
  endfunction

  // ---------------- driver: one full transaction ----------------
  // Called at a falling edge. hold = cycles out_ready stays low after
  // out_valid is first seen.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] er, r0;
    logic        ei, i0;
    int          n, lat, busy_bad, stable_bad;
    bit          is_mul;
    ref_model(op, a, b, er, ei);
    exp_q.push_back(er);
    expi_q.push_back(ei);
    is_mul = (op inside {6'b010000, 6'b010001, 6'b010010, 6'b010011});

    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ready_before"}, 32'(in_ready), 32'd1);

    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    // Keep requesting junk while busy: it must neither be taken nor disturb the op.
    in_op = 6'($urandom); in_a = $urandom; in_b = $urandom;

    lat = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) busy_bad++;
    end while (!out_valid && lat < 60);
    in_valid = 1'b0;

    check({tag, "_latency"}, 32'(lat), is_mul ? 32'd34 : 32'd1);
    check({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check({tag, "_result"}, out_result, exp_q.pop_front());
    check({tag, "_illegal"}, 32'(out_illegal), 32'(expi_q.pop_front()));

    r0 = out_result; i0 = out_illegal; stable_bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_result !== r0 || out_illegal !== i0) stable_bad++;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 32'(stable_bad), 32'd0);

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0]  op_tab[14] = '{6'b000000, 6'b000001, 6'b000010, 6'b000110, 6'b000111,
                              6'b001010, 6'b001001, 6'b001011, 6'b001100, 6'b001101,
                              6'b010000, 6'b010001, 6'b010010, 6'b010011};
  logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0024};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    #1;
    check("reset_state", {29'b0, in_ready, out_valid, out_illegal}, 32'b100);
    check("reset_result", out_result, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(6'b000010, 32'hFFFF_FFFF, 32'h1,           0, "add_wrap");
    do_op(6'b000110, 32'h0,         32'h1,           0, "sub_wrap");
    do_op(6'b001010, 32'hFFFF_FFFF, 32'h1,           0, "slt");
    do_op(6'b001001, 32'hFFFF_FFFF, 32'h1,           0, "sltu");
    do_op(6'b001101, 32'h8000_0000, 32'h0000_0024,   0, "sra");
    do_op(6'b001100, 32'h8000_0000, 32'h0000_0024,   0, "srl");
    do_op(6'b010000, 32'h8000_0000, 32'h8000_0000,   0, "mul_min");
    do_op(6'b010001, 32'h8000_0000, 32'h8000_0000,   0, "mulh_min");
    do_op(6'b010011, 32'h8000_0000, 32'h8000_0000,   0, "mulhu_min");
    do_op(6'b010010, 32'h8000_0000, 32'h8000_0000,   0, "mulhsu_min");
    do_op(6'b010001, 32'hFFFF_FFFF, 32'h3,           0, "mulh_m1");
    do_op(6'b010000, 32'hFFFF_FFFF, 32'h3,           0, "mul_m1");
    do_op(6'b010011, 32'hFFFF_FFFF, 32'h3,           0, "mulhu_m1");
    do_op(6'b110000, 32'h1234_5678, 32'h9ABC_DEF0,   5, "fp_illegal");
    do_op(6'b111111, 32'h1,         32'h2,           2, "ff_illegal");

    // Reset in the middle of a multiply
    in_valid = 1'b1; in_op = 6'b010000; in_a = 32'h0001_0003; in_b = 32'h0000_0007;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midmul_reset_flags", {29'b0, in_ready, out_valid, out_illegal}, 32'b100);
    check("midmul_reset_result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(6'b000010, 32'd2, 32'd3, 0, "add_after_reset");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 13)];
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      do_op(op, a, b, $urandom_range(0, 3), $sformatf("rand%0d_op%02h", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", compared);
    $fatal(1, "time limit reached");
  end

endmodule
